// File: rtl/div_sched.sv
// HI/LO owner and sequencer for the shared iterative divider.
// Optional macro DIV_ZERO_SKIP_EN: a zero divisor finishes early through the ZERO state.
module div_sched (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_en,
    output logic        div_signed_o,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ZERO = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] x_q, x_d, y_q, y_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        div_en_q, done_q;
    logic        fire, commit;
    logic [31:0] commitHi, commitLo;

    // The divider corrects signs from x/y at its output, so its operands must
    // come from the latched copies and stay put until the commit.
    always_comb begin
        fire     = req_valid & (state_q == IDLE) & ~flush;
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sgn_d    = sgn_q;
        commit   = 1'b0;
        commitHi = hi_q;
        commitLo = lo_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    x_d   = req_x;
                    y_d   = req_y;
                    sgn_d = req_signed;
`ifdef DIV_ZERO_SKIP_EN
                    state_d = (req_y == 32'd0) ? ZERO : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_complete) begin
                    commit   = 1'b1;
                    commitHi = div_r;
                    commitLo = div_s;
                    state_d  = IDLE;
                end
            end
`ifdef DIV_ZERO_SKIP_EN
            ZERO: begin
                // A flush kills this shortcut just like a running divide.
                if (!flush) begin
                    commit   = 1'b1;
                    commitHi = x_q;
                    commitLo = 32'hFFFF_FFFF;
                end
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A divide commit wins over a same-cycle MTHI/MTLO, which is then lost.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = commitHi;
            lo_d = commitLo;
        end else begin
            if (mthi) hi_d = mt_data;
            if (mtlo) lo_d = mt_data;
        end
    end

    // div_en follows the next state so it falls right after complete and the
    // divider counter clears before it can wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            sgn_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            div_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sgn_q    <= sgn_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_en_q <= (state_d == RUN);
            done_q   <= commit;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_en       = div_en_q;
    assign div_signed_o = sgn_q;
    assign div_x        = x_q;
    assign div_y        = y_q;

endmodule

// File: tb/tb_div_sched.sv
// Randomised self-checking bench for div_sched with a behavioural 34-cycle divider.
// Honours DIV_ZERO_SKIP_EN for zero-divisor latency.
module tb_div_sched;

    logic        clk = 1'b0;
    logic        resetn, req_valid, req_ready, req_signed, flush, busy, done;
    logic        mthi, mtlo, div_en, div_signed_o, div_complete;
    logic [31:0] req_x, req_y, mt_data, hi, lo, div_x, div_y, div_s, div_r;

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] refHi = 32'd0;
    logic [31:0] refLo = 32'd0;
    logic [5:0]  divCnt = 6'd0;

    always #5 clk = ~clk;

    div_sched dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_x(req_x), .req_y(req_y), .flush(flush),
        .busy(busy), .done(done), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .hi(hi), .lo(lo), .div_en(div_en), .div_signed_o(div_signed_o),
        .div_x(div_x), .div_y(div_y), .div_s(div_s), .div_r(div_r),
        .div_complete(div_complete)
    );

    // Architectural divide result {quotient, remainder}, truncating toward zero.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {x, 32'd0};
        if (sgn) return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
        return {x / y, x % y};
    endfunction

    // Stand-in divider: complete on the 34th consecutive enabled cycle.
    always @(posedge clk) begin
        if (!div_en) divCnt <= 6'd0;
        else         divCnt <= divCnt + 6'd1;
    end
    assign div_complete = div_en && (divCnt == 6'd33);
    assign {div_s, div_r} = refDiv(div_signed_o, div_x, div_y);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    // Fires one divide at the current negedge and follows it cycle by cycle.
    // cutAt: cycle offset of a flush (or of a reset when useReset), -1 for none.
    // mtAt:  cycle offset of an MTHI/MTLO write, -1 for none.
    task automatic applyStimulus(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                                 input int cutAt, input bit useReset,
                                 input int mtAt, input bit mtHiSel, input logic [31:0] mtVal);
        int lat;
        logic [63:0] res;
        lat = 35;
`ifdef DIV_ZERO_SKIP_EN
        if (y == 32'd0) lat = 2;
`endif
        if (mtAt >= lat) mtAt = -1;
        res = refDiv(sgn, x, y);
        checkOutput("ready_before_fire", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_signed = sgn; req_x = x; req_y = y;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_valid = 1'b0; req_x = $urandom; req_y = $urandom; req_signed = 1'($urandom);
            mthi = 1'b0; mtlo = 1'b0; flush = 1'b0; resetn = 1'b1;
            if (mtAt >= 1 && k == mtAt + 1 && k < lat) begin
                if (mtHiSel) refHi = mtVal;
                else         refLo = mtVal;
            end
            if (cutAt >= 1 && k == cutAt + 1) begin
                if (useReset) begin refHi = 32'd0; refLo = 32'd0; end
                checkOutput("cut_ready", {31'd0, req_ready}, 32'd1);
                checkOutput("cut_busy", {31'd0, busy}, 32'd0);
                checkOutput("cut_div_en", {31'd0, div_en}, 32'd0);
                checkOutput("cut_done", {31'd0, done}, 32'd0);
                checkOutput("cut_hi", hi, refHi);
                checkOutput("cut_lo", lo, refLo);
                return;
            end
            if (k == lat) begin refLo = res[63:32]; refHi = res[31:0]; end
            checkOutput("div_en", {31'd0, div_en}, {31'd0, (lat == 35 && k <= 34)});
            checkOutput("done", {31'd0, done}, {31'd0, (k == lat)});
            checkOutput("busy", {31'd0, busy}, {31'd0, (k < lat)});
            checkOutput("hi", hi, refHi);
            checkOutput("lo", lo, refLo);
            if (k == cutAt) begin
                if (useReset) resetn = 1'b0;
                else          flush = 1'b1;
            end
            if (k == mtAt) begin
                mt_data = mtVal;
                if (mtHiSel) mthi = 1'b1;
                else         mtlo = 1'b1;
            end
        end
    endtask

    initial begin
        logic        rs;
        logic [31:0] rx, ry;
        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_x = 32'd0; req_y = 32'd0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; mt_data = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_div_en", {31'd0, div_en}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        resetn = 1'b1;

        // MT writes while idle
        mthi = 1'b1; mt_data = 32'hA5A5_0001;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h5A5A_0002;
        refHi = 32'hA5A5_0001;
        checkOutput("idle_mthi", hi, refHi);
        @(negedge clk);
        mtlo = 1'b0;
        refLo = 32'h5A5A_0002;
        checkOutput("idle_mtlo", lo, refLo);

        applyStimulus(1'b0, 32'd100, 32'd7, -1, 1'b0, -1, 1'b0, 32'd0);
        checkOutput("divu_100_7_lo", lo, 32'd14);
        checkOutput("divu_100_7_hi", hi, 32'd2);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, -1, 1'b0, 32'd0);
        checkOutput("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_m7_2_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(1'b0, 32'd50, 32'd5, 10, 1'b0, -1, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd9, 32'd4, -1, 1'b0, -1, 1'b0, 32'd0);
        checkOutput("divu_9_4_lo", lo, 32'd2);
        checkOutput("divu_9_4_hi", hi, 32'd1);

        applyStimulus(1'b0, 32'd1000, 32'd33, -1, 1'b0, 5, 1'b1, 32'h1234);
        applyStimulus(1'b0, 32'd77, 32'd10, -1, 1'b0, 34, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'd500, 32'd3, 34, 1'b0, -1, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd8, 32'd0, -1, 1'b0, -1, 1'b0, 32'd0);
        checkOutput("divu_8_0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("divu_8_0_hi", hi, 32'd8);

        // flush alongside a request in IDLE must not start a divide
        req_valid = 1'b1; flush = 1'b1; req_x = 32'd6; req_y = 32'd3;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_idle_div_en", {31'd0, div_en}, 32'd0);
        checkOutput("flush_idle_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b0, 32'd1000, 32'd3, 20, 1'b1, -1, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("post_rst_complete", {31'd0, div_complete}, 32'd0);
            checkOutput("post_rst_done", {31'd0, done}, 32'd0);
        end

        for (int n = 0; n < 10; n++) begin
            rs = 1'($urandom);
            rx = $urandom;
            ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) ry = ry % 32'd100;
            if (rs && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF) ry = 32'd3;
            applyStimulus(rs, rx, ry, -1, 1'b0,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 34)) : -1,
                          1'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Controller that owns the shared iterative divider in the EX/MEM path and the HI/LO register pair. It accepts DIV/DIVU requests from EX over a valid/ready handshake and latches the operands. It holds the divider's `div` enable and operands stable until `complete`, then commits quotient to LO and remainder to HI. It also services MTHI/MTLO writes, exposes HI/LO for MFHI/MFLO, and supports pipeline flush.

## Interface
- No parameters; all widths are fixed at 32 bits.
- `clk  in  1`: single clock for the block and the attached divider.
- `resetn  in  1`: synchronous, active-low reset.
- `req_valid  in  1`: EX presents a divide.
- `req_ready  out  1`: block can accept; equals `state==IDLE`.
- `req_signed  in  1`: 1 = DIV, 0 = DIVU.
- `req_x, req_y  in  32`: dividend and divisor.
- `flush  in  1`: cancel any in-flight divide (exception or eret).
- `busy  out  1`: divide in flight; the pipeline stalls MFHI/MFLO while high.
- `done  out  1`: one-cycle pulse in the first cycle new HI/LO are visible.
- `mthi, mtlo  in  1`: write enables.
- `mt_data  in  32`: write data for MTHI/MTLO.
- `hi, lo  out  32`: current HI/LO register values.
- `div_en  out  1`: drives the divider `div` input.
- `div_signed_o  out  1`: drives the divider `div_signed` input.
- `div_x, div_y  out  32`: drive the divider `x`/`y` inputs.
- `div_s, div_r  in  32`: divider quotient and remainder.
- `div_complete  in  1`: divider complete flag.

## Operation
- States: IDLE, RUN, and ZERO (ZERO exists only with the macro).
- Fire = `req_valid & req_ready & ~flush`.
- On fire, latch `req_x`, `req_y` and `req_signed` into operand registers.
- `div_x`, `div_y` and `div_signed_o` come from these registers only. They never come from the request ports, because the divider fixes up signs combinationally from `x`/`y` at its output.
- IDLE → RUN on fire. With DIV_ZERO_SKIP_EN and `req_y==0`, IDLE → ZERO instead.
- RUN:
  - `div_en` = 1.
  - If `flush`: go to IDLE, no commit.
  - Else if `div_complete`: write LO←`div_s` and HI←`div_r`, pulse `done` next cycle, go to IDLE.
- `div_en` is registered as `next_state==RUN`. It therefore drops the cycle after `complete`, which returns the divider counter to 0 before it can wrap.
- ZERO (one cycle): commit LO←32'hFFFFFFFF and HI←latched x, go to IDLE. `div_en` is never asserted.
- HI/LO write priority: reset > divide commit > `mthi`/`mtlo`.
  - An MT in the same cycle as a commit to the same register is dropped.
  - MT during RUN without a commit that cycle is applied; the later commit overwrites it.
- `busy` = `state!=IDLE`. `hi`/`lo` are the registers directly; there is no bypass.
- Reset values:
  - state = IDLE.
  - `hi`, `lo`, operand registers = 0.
  - `div_en`, `done`, `busy` = 0.
  - `req_ready` = 1.
- Reset mid-operation forces IDLE with no commit. `div_en` is 0 the following cycle.

## Timing
- Fire at cycle T → `div_en` = 1 from T+1.
- The divider asserts `complete` at T+34 (its 34th enabled cycle).
- HI/LO are updated and `done` = 1 in T+35.
- `req_ready` = 1 in T+35, so back-to-back divides accept at T+35 at the earliest.
- `flush` in RUN at cycle F:
  - `div_en` = 0 and `req_ready` = 1 at F+1.
  - A `flush` in the same cycle as `div_complete` also suppresses the commit.
- `flush` together with `req_valid` in IDLE: the request is not accepted.
- ZERO path: fire at T → commit, `done` = 1 and `req_ready` = 1 in T+2.

## Configuration
- Macro `DIV_ZERO_SKIP_EN`.
- Defined: a divisor of 0 takes the ZERO path, completing in 2 cycles with LO=32'hFFFFFFFF and HI=x regardless of `req_signed`.
- Undefined: a divisor of 0 runs the full 35-cycle divider sequence and commits whatever the divider produces. That is LO=32'hFFFFFFFF, HI=x for DIVU.
- Both builds give identical unsigned results; only latency differs.

## Test plan
- DIVU x=100, y=7, fire at T → `done`, LO=14, HI=2 at T+35; `div_en` high exactly T+1..T+34.
- DIV x=-7 (32'hFFFFFFF9), y=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Changing `req_x` after fire has no effect on the result.
- Flush at T+10 of a DIVU 50/5 → HI/LO unchanged, no `done`, `req_ready`=1 at T+11. A new DIVU 9/4 fired at T+11 gives LO=2, HI=1 at T+46.
- `mthi` 32'h1234 at T+5 during RUN → `hi`=32'h1234 from T+6, then overwritten by the remainder at T+35. `mtlo` coincident with commit at T+34 → dropped.
- DIVU 8/0: with the macro → LO=32'hFFFFFFFF, HI=8 at T+2 and `div_en` never high. Without the macro → same values at T+35.
- `resetn`=0 at T+20 → `hi`=`lo`=0, `busy`=0, `div_en`=0 at T+21; the divider's `complete` is never seen.
